spi_reg_bank: RTL and testbench

Register bank that sits directly downstream of the SPI slave. It consumes the slave's received bytes (`din`) and one-cycle `done` strobes, decodes a two-byte command protocol (command byte, then data byte), updates an internal array of 8-bit registers on writes, and drives `dout` back to the slave for the transmit byte of reads. The register contents are exported to the rest of the design as a flat vector, alongside a write strobe.

---
 rtl/spi_reg_bank.sv | 150 +++++++++++++++
 tb/tb_spi_reg_bank.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// Register bank behind an SPI slave: two-byte command/data protocol, flat register export, sticky error.
// Optional write lock on register 0 enabled with SPI_REGS_LOCK_EN.
module spi_reg_bank #(
    parameter int NREGS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ss,
    input  logic [7:0]         din,
    input  logic               done,
    output logic [7:0]         dout,
    output logic [NREGS*8-1:0] regs,
    output logic               wr_stb,
    output logic [6:0]         wr_addr,
    output logic               err
);

    typedef enum logic [1:0] {
        ST_CMD    = 2'd0,
        ST_DATA   = 2'd1,
        ST_TXWAIT = 2'd2
    } state_t;

    localparam logic [6:0] STATUS_ADDR = 7'h7F;
    localparam logic [6:0] NREGS_A     = 7'(NREGS);

    state_t     state_q;
    logic       op_rd_q;
    logic [6:0] addr_q;
    logic       rd_load_q;
    logic [7:0] dout_q;
    logic       wr_stb_q;
    logic [6:0] wr_addr_q;
    logic       err_q;
    logic       err_d;
    logic [7:0] regs_q [NREGS];
    logic [7:0] rd_val;

    logic data_done;
    logic addr_valid;
    logic is_status;
    logic lock_ok;
    logic wr_commit;
    logic wr_reject;
    logic rd_bad;
    logic status_clr;

    // A done while ss is high belongs to no frame and is dropped.
    assign data_done  = done && !ss && (state_q == ST_DATA);
    assign addr_valid = addr_q < NREGS_A;
    assign is_status  = addr_q == STATUS_ADDR;

`ifdef SPI_REGS_LOCK_EN
    assign lock_ok = (addr_q == 7'd0) || (regs_q[0] == 8'hA5);
`else
    assign lock_ok = 1'b1;
`endif

    assign wr_commit  = data_done && !op_rd_q && addr_valid && lock_ok;
    assign wr_reject  = data_done && !op_rd_q && !is_status && !(addr_valid && lock_ok);
    assign rd_bad     = rd_load_q && !addr_valid && !is_status;
    assign status_clr = data_done && op_rd_q && is_status;

    always_comb begin
        rd_val = 8'hFF;
        if (is_status) begin
            rd_val = {7'b0, err_q};
        end
        for (int i = 0; i < NREGS; i++) begin
            if (7'(i) == addr_q) begin
                rd_val = regs_q[i];
            end
        end
    end

    always_comb begin
        err_d = err_q;
        if (wr_reject || rd_bad) begin
            err_d = 1'b1;
        end else if (status_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CMD;
            op_rd_q   <= 1'b0;
            addr_q    <= 7'd0;
            rd_load_q <= 1'b0;
            dout_q    <= 8'h00;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= 7'd0;
            err_q     <= 1'b0;
        end else begin
            wr_stb_q  <= wr_commit;
            if (wr_commit) begin
                wr_addr_q <= addr_q;
            end
            err_q     <= err_d;
            // Read data is fetched one cycle after the command so addr_q is settled.
            rd_load_q <= 1'b0;
            if (rd_load_q) begin
                dout_q <= rd_val;
            end
            if (ss) begin
                state_q <= ST_CMD;
            end else if (done) begin
                case (state_q)
                    ST_CMD: begin
                        op_rd_q   <= din[7];
                        addr_q    <= din[6:0];
                        rd_load_q <= din[7];
                        state_q   <= ST_DATA;
                    end
                    ST_DATA:   state_q <= op_rd_q ? ST_TXWAIT : ST_CMD;
                    ST_TXWAIT: state_q <= ST_TXWAIT;
                    default:   state_q <= ST_CMD;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_commit) begin
            for (int i = 0; i < NREGS; i++) begin
                if (7'(i) == addr_q) begin
                    regs_q[i] <= din;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_flat
            assign regs[gi*8 +: 8] = regs_q[gi];
        end
    endgenerate

    assign dout    = dout_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign err     = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: vector table, hand-written corner sequences, random frames vs model.
module tb_spi_reg_bank;
    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           ss;
    logic [7:0]     din;
    logic           done;
    logic [7:0]     dout;
    logic [N*8-1:0] regs;
    logic           wr_stb;
    logic [6:0]     wr_addr;
    logic           err;

    spi_reg_bank #(.NREGS(N)) dut (
        .clk(clk), .rst(rst), .ss(ss), .din(din), .done(done),
        .dout(dout), .regs(regs), .wr_stb(wr_stb), .wr_addr(wr_addr), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int stb_cnt = 0;

    always @(negedge clk) if (wr_stb === 1'b1) stb_cnt++;

    // Behavioural model of the protocol, updated per received byte.
    logic [7:0] m_regs [N];
    logic       m_err = 1'b0;
    logic [7:0] m_dout = 8'h00;
    logic [6:0] m_wr_addr = 7'd0;
    int         m_stb = 0;
    int         m_phase = 0;   // 0 expect command, 1 expect data, 2 waiting for ss
    logic       m_rd = 1'b0;
    int         m_addr = 0;

    function automatic logic m_locked(input int a);
`ifdef SPI_REGS_LOCK_EN
        return (a != 0) && (m_regs[0] != 8'hA5);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void m_rx(input logic [7:0] b);
        if (m_phase == 0) begin
            m_rd    = b[7];
            m_addr  = int'(b[6:0]);
            m_phase = 1;
            if (m_rd) begin
                if (m_addr < N)          m_dout = m_regs[m_addr];
                else if (m_addr == 127)  m_dout = {7'b0, m_err};
                else begin m_dout = 8'hFF; m_err = 1'b1; end
            end
        end else if (m_phase == 1) begin
            if (m_rd) begin
                if (m_addr == 127) m_err = 1'b0;
                m_phase = 2;
            end else begin
                m_phase = 0;
                if (m_addr == 127) begin
                end else if (m_addr >= N || m_locked(m_addr)) begin
                    m_err = 1'b1;
                end else begin
                    m_regs[m_addr] = b;
                    m_wr_addr = 7'(m_addr);
                    m_stb++;
                end
            end
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
        m_err = 1'b0; m_dout = 8'h00; m_wr_addr = 7'd0; m_phase = 0;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [N*8-1:0] exp_regs;
        for (int i = 0; i < N; i++) exp_regs[i*8 +: 8] = m_regs[i];
        chk({tag, "_regs"}, 128'(regs), 128'(exp_regs));
        chk({tag, "_err"}, 128'(err), 128'(m_err));
        chk({tag, "_dout"}, 128'(dout), 128'(m_dout));
        chk({tag, "_stbcnt"}, 128'(stb_cnt), 128'(m_stb));
        chk({tag, "_wraddr"}, 128'(wr_addr), 128'(m_wr_addr));
    endtask

    task automatic pulse(input logic [7:0] b);
        @(posedge clk); #1;
        din = b; done = 1'b1;
        if (!ss) m_rx(b);
        @(posedge clk); #1;
        done = 1'b0;
    endtask

    task automatic set_ss(input logic v);
        @(posedge clk); #1;
        ss = v;
        if (v) m_phase = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] d);
        set_ss(1'b0); pulse(c); idle(2); pulse(d); idle(2); set_ss(1'b1); idle(2);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] dat;
        logic       exp_err;
        logic [7:0] exp_dout;
        int         exp_stb;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{8'h03, 8'h5C, 1'b0, 8'h00, 1};
        tbl[1] = '{8'h83, 8'h00, 1'b0, 8'h5C, 0};
        tbl[2] = '{8'h20, 8'h11, 1'b1, 8'h5C, 0};
        tbl[3] = '{8'h90, 8'h00, 1'b1, 8'hFF, 0};
        tbl[4] = '{8'hFF, 8'h00, 1'b0, 8'h01, 0};
        tbl[5] = '{8'h7F, 8'h12, 1'b0, 8'h01, 0};
        tbl[6] = '{8'h05, 8'h77, 1'b0, 8'h01, 1};
        tbl[7] = '{8'h85, 8'hAA, 1'b0, 8'h77, 0};
        tbl[8] = '{8'hFF, 8'h00, 1'b0, 8'h00, 0};

        m_reset();
        rst = 1'b1; ss = 1'b1; done = 1'b0; din = 8'h00;
        idle(3);
        chk("rst_regs", 128'(regs), 128'd0);
        chk("rst_dout", 128'(dout), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        chk("rst_wrstb", 128'(wr_stb), 128'd0);
        chk("rst_wraddr", 128'(wr_addr), 128'd0);
        rst = 1'b0;
        idle(2);

`ifdef SPI_REGS_LOCK_EN
        frame(8'h00, 8'hA5);
`endif

        for (int i = 0; i < 9; i++) begin
            int s0;
            s0 = stb_cnt;
            frame(tbl[i].cmd, tbl[i].dat);
            chk($sformatf("tbl%0d_err", i), 128'(err), 128'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_dout", i), 128'(dout), 128'(tbl[i].exp_dout));
            chk($sformatf("tbl%0d_stb", i), 128'(stb_cnt - s0), 128'(tbl[i].exp_stb));
            check_all($sformatf("tbl%0d", i));
        end
        chk("tbl_reg3", 128'(regs[3*8 +: 8]), 128'(8'h5C));

        // Write latency: regs and wr_stb visible right after the DATA edge, strobe lasts one cycle.
        set_ss(1'b0); pulse(8'h0A); idle(2);
        @(posedge clk); #1; din = 8'hC3; done = 1'b1; m_rx(8'hC3);
        @(negedge clk);
        chk("lat_reg_early", 128'(regs[10*8 +: 8]), 128'(8'h00));
        @(negedge clk);
        chk("lat_reg", 128'(regs[10*8 +: 8]), 128'(8'hC3));
        chk("lat_stb_hi", 128'(wr_stb), 128'd1);
        chk("lat_wraddr", 128'(wr_addr), 128'(7'h0A));
        #1 done = 1'b0;
        @(negedge clk);
        chk("lat_stb_lo", 128'(wr_stb), 128'd0);

        // Read data available one cycle after the command done.
        pulse(8'h8A);
        @(posedge clk); #1;
        chk("rd_timing_dout", 128'(dout), 128'(8'hC3));
        pulse(8'h00); idle(1); set_ss(1'b1); idle(2);
        check_all("rd_timing");

        // Back-to-back: command done in the cycle right after a write's data done.
        set_ss(1'b0); pulse(8'h06); idle(2);
        @(posedge clk); #1; din = 8'h9A; done = 1'b1; m_rx(8'h9A);
        @(posedge clk); #1; din = 8'h86; m_rx(8'h86);
        @(posedge clk); #1; done = 1'b0;
        idle(2);
        chk("b2b_dout", 128'(dout), 128'(8'h9A));
        pulse(8'h00); idle(1); set_ss(1'b1); idle(2);
        check_all("b2b");

        // Frame abort after command, then done ignored while ss high.
        set_ss(1'b0); pulse(8'h05); idle(2); set_ss(1'b1); idle(2);
        chk("abort_reg5", 128'(regs[5*8 +: 8]), 128'(8'h77));
        pulse(8'h08);
        set_ss(1'b0); pulse(8'h09); idle(2); pulse(8'h5A); idle(2); set_ss(1'b1); idle(2);
        chk("ssdone_reg9", 128'(regs[9*8 +: 8]), 128'(8'h5A));
        chk("ssdone_reg8", 128'(regs[8*8 +: 8]), 128'(8'h00));
        frame(8'h05, 8'h3C);
        chk("abort_next_reg5", 128'(regs[5*8 +: 8]), 128'(8'h3C));
        check_all("abort");

        // Asynchronous reset mid-frame.
        frame(8'h20, 8'h11);
        chk("pre_rst_err", 128'(err), 128'd1);
        set_ss(1'b0); pulse(8'h04); idle(1);
        #2 rst = 1'b1;
        #1;
        chk("arst_regs", 128'(regs), 128'd0);
        chk("arst_dout", 128'(dout), 128'd0);
        chk("arst_err", 128'(err), 128'd0);
        chk("arst_wrstb", 128'(wr_stb), 128'd0);
        chk("arst_wraddr", 128'(wr_addr), 128'd0);
        m_reset();
        @(posedge clk); #1 rst = 1'b0;
        set_ss(1'b1); idle(1);
`ifdef SPI_REGS_LOCK_EN
        frame(8'h00, 8'hA5);
`endif
        frame(8'h04, 8'hAB);
        chk("arst_next_reg4", 128'(regs[4*8 +: 8]), 128'(8'hAB));
        check_all("arst");

`ifdef SPI_REGS_LOCK_EN
        frame(8'h00, 8'h00);
        frame(8'h02, 8'h33);
        chk("lock_rej_err", 128'(err), 128'd1);
        chk("lock_rej_reg2", 128'(regs[2*8 +: 8]), 128'd0);
        frame(8'hFF, 8'h00);
        frame(8'h00, 8'hA5);
        frame(8'h02, 8'h33);
        chk("lock_ok_reg2", 128'(regs[2*8 +: 8]), 128'(8'h33));
        check_all("lock");
`endif

        for (int t = 0; t < 150; t++) begin
            logic [7:0] c;
            logic [7:0] d;
            int sel;
            logic abort;
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       c[6:0] = 7'($urandom_range(0, N - 1));
            else if (sel < 8)  c[6:0] = 7'($urandom_range(N, N + 4));
            else if (sel == 8) c[6:0] = 7'h7F;
            else               c[6:0] = 7'($urandom);
            c[7]  = 1'($urandom);
            d     = 8'($urandom);
            abort = ($urandom_range(0, 7) == 0);
            set_ss(1'b0); pulse(c); idle(1 + int'($urandom_range(0, 2)));
            if (!abort) pulse(d);
            idle(1 + int'($urandom_range(0, 2)));
            set_ss(1'b1); idle(2);
            check_all($sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
